// File: rtl/uart_tx_arbiter_pkg.sv
// Shared types for the UART TX arbiter: FSM state encoding and grant-index width.
package uart_tx_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE   = 2'd0,
    ARB_SEND   = 2'd1,
    ARB_STROBE = 2'd2,
    ARB_SETTLE = 2'd3
  } arb_state_e;

  // Width of a requester index; a single requester still needs one bit.
  function automatic int arb_grant_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Combinational round-robin select: first valid requester after the last grant.
module uart_tx_arbiter_rr_pick
  import uart_tx_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int GRANT_W = 1
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [GRANT_W-1:0] last_i,
  output logic [GRANT_W-1:0] pick_o,
  output logic               any_o
);

  int idx;

  always_comb begin
    pick_o = last_i;
    any_o  = 1'b0;
    idx    = 0;
    // Searching last+1 first makes the previous owner the lowest priority.
    for (int i = 1; i <= NUM_REQ; i++) begin
      idx = (int'(last_i) + i) % NUM_REQ;
      if (!any_o && req_i[idx]) begin
        pick_o = GRANT_W'(idx);
        any_o  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Packet-granular round-robin arbiter sharing one serial TX byte channel among NUM_REQ streams.
//   state      | meaning
//   ARB_IDLE   | no owner; pick next requester round-robin
//   ARB_SEND   | owner holds grant; wait for byte with channel free, count owner idle cycles
//   ARB_STROBE | new_tx_data pulse with registered byte
//   ARB_SETTLE | dead cycle so tx_busy reflects the new byte
module uart_tx_arbiter
  import uart_tx_arbiter_pkg::*;
#(
  parameter int NUM_REQ      = 2,
  parameter int IDLE_TIMEOUT = 1024,
  localparam int GRANT_W     = arb_grant_w(NUM_REQ)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [8*NUM_REQ-1:0] req_data,
  input  logic [NUM_REQ-1:0]   req_last,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic [7:0]           tx_data,
  output logic                 new_tx_data,
  input  logic                 tx_busy,
  input  logic                 tx_block,
  output logic [GRANT_W-1:0]   grant_id,
  output logic                 grant_active,
  output logic                 timeout_evt
);

  localparam int               CNT_W  = $clog2(IDLE_TIMEOUT) + 1;
  localparam logic [CNT_W-1:0] CNT_TC = CNT_W'(IDLE_TIMEOUT - 1);

  arb_state_e         state_q, state_d;
  logic [GRANT_W-1:0] grant_id_q, grant_id_d;
  logic               grant_active_q, grant_active_d;
  logic [7:0]         tx_data_q, tx_data_d;
  logic               last_q, last_d;
  logic [CNT_W-1:0]   idle_cnt_q, idle_cnt_d;
  logic               timeout_q, timeout_d;
  logic [GRANT_W-1:0] pick;
  logic               pick_any;
  logic               accept;

  uart_tx_arbiter_rr_pick #(
    .NUM_REQ (NUM_REQ),
    .GRANT_W (GRANT_W)
  ) u_rr_pick (
    .req_i  (req_valid),
    .last_i (grant_id_q),
    .pick_o (pick),
    .any_o  (pick_any)
  );

  assign accept = (state_q == ARB_SEND) && req_valid[grant_id_q] && !tx_busy && !tx_block;

  always_comb begin
    state_d        = state_q;
    grant_id_d     = grant_id_q;
    grant_active_d = grant_active_q;
    tx_data_d      = tx_data_q;
    last_d         = last_q;
    idle_cnt_d     = idle_cnt_q;
    timeout_d      = 1'b0;
    case (state_q)
      ARB_IDLE: begin
        if (pick_any) begin
          grant_id_d     = pick;
          grant_active_d = 1'b1;
          idle_cnt_d     = '0;
          state_d        = ARB_SEND;
        end
      end
      ARB_SEND: begin
        if (accept) begin
          tx_data_d  = req_data[{grant_id_q, 3'b000} +: 8];
          last_d     = req_last[grant_id_q];
          idle_cnt_d = '0;
          state_d    = ARB_STROBE;
        end else if (!req_valid[grant_id_q]) begin
          // Only an absent owner counts; channel stalls hold the counter.
          if (idle_cnt_q == CNT_TC) begin
            timeout_d      = 1'b1;
            grant_active_d = 1'b0;
            idle_cnt_d     = '0;
            state_d        = ARB_IDLE;
          end else begin
            idle_cnt_d = idle_cnt_q + 1'b1;
          end
        end
      end
      ARB_STROBE: state_d = ARB_SETTLE;
      ARB_SETTLE: begin
        if (last_q) begin
          grant_active_d = 1'b0;
          state_d        = ARB_IDLE;
        end else begin
          state_d = ARB_SEND;
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= ARB_IDLE;
      grant_id_q     <= GRANT_W'(NUM_REQ - 1);
      grant_active_q <= 1'b0;
      tx_data_q      <= 8'h00;
      last_q         <= 1'b0;
      idle_cnt_q     <= '0;
      timeout_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      grant_id_q     <= grant_id_d;
      grant_active_q <= grant_active_d;
      tx_data_q      <= tx_data_d;
      last_q         <= last_d;
      idle_cnt_q     <= idle_cnt_d;
      timeout_q      <= timeout_d;
    end
  end

  // Gated by rst so a reset landing mid-packet never leaks a strobe or accept.
  always_comb begin
    req_ready = '0;
    if (accept && !rst) req_ready[grant_id_q] = 1'b1;
  end

  assign new_tx_data  = (state_q == ARB_STROBE) && !rst;
  assign tx_data      = tx_data_q;
  assign grant_id     = grant_id_q;
  assign grant_active = grant_active_q;
  assign timeout_evt  = timeout_q;

endmodule
